// File: rtl/hbm_narrow.sv
// rtl/hbm_narrow.sv - 256-bit slave to 512-bit master AXI4 INCR burst upsizer
// Ports: aclk/aresetn; s_axi_{ar,aw,w,r,b}* 256-bit AXI4 slave;
//        m_axi_{ar,aw,w,r,b}* 512-bit AXI4 master (no R/B id on master side).
// Optional: HBM_NARROW_BURST_CHECK_EN rejects non-32B or non-INCR requests with SLVERR.
module hbm_narrow #(
  parameter int ADDR_BITS = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [ADDR_BITS-1:0] s_axi_araddr,
  input  logic [7:0]           s_axi_arlen,
  input  logic [2:0]           s_axi_arsize,
  input  logic [1:0]           s_axi_arburst,
  input  logic                 s_axi_arid,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  input  logic [ADDR_BITS-1:0] s_axi_awaddr,
  input  logic [7:0]           s_axi_awlen,
  input  logic [2:0]           s_axi_awsize,
  input  logic [1:0]           s_axi_awburst,
  input  logic                 s_axi_awid,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [255:0]         s_axi_wdata,
  input  logic [31:0]          s_axi_wstrb,
  input  logic                 s_axi_wlast,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [255:0]         s_axi_rdata,
  output logic                 s_axi_rid,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rlast,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic                 s_axi_bid,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  output logic [ADDR_BITS-1:0] m_axi_araddr,
  output logic [7:0]           m_axi_arlen,
  output logic [2:0]           m_axi_arsize,
  output logic [1:0]           m_axi_arburst,
  output logic                 m_axi_arid,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  output logic [ADDR_BITS-1:0] m_axi_awaddr,
  output logic [7:0]           m_axi_awlen,
  output logic [2:0]           m_axi_awsize,
  output logic [1:0]           m_axi_awburst,
  output logic                 m_axi_awid,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [511:0]         m_axi_wdata,
  output logic [63:0]          m_axi_wstrb,
  output logic                 m_axi_wlast,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [511:0]         m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rlast,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready
);

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

  // Master beat count: slave beats plus the leading empty half when addr[5]=1, halved.
  function automatic logic [7:0] up_len(input logic a5, input logic [7:0] len);
    logic [8:0] sum;
    sum = {1'b0, len} + {8'b0, a5};
    return sum[8:1];
  endfunction

  logic                 live;  // keeps address readies low until the first clock after reset
  rd_state_t            rd_state;
  logic                 rd_h, rd_id, rd_err;
  logic [7:0]           rd_n, rd_len;
  logic [ADDR_BITS-1:0] rd_addr;
  wr_state_t            wr_state;
  logic                 wr_h, wr_id, wr_err;
  logic [7:0]           wr_len;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [255:0]         buf_data;
  logic [31:0]          buf_strb;
  logic                 ar_bad, aw_bad, wr_pass;
  logic                 unused_ok;

`ifdef HBM_NARROW_BURST_CHECK_EN
  assign ar_bad = (s_axi_arsize != 3'b101) || (s_axi_arburst != 2'b01);
  assign aw_bad = (s_axi_awsize != 3'b101) || (s_axi_awburst != 2'b01);
`else
  assign ar_bad = 1'b0;
  assign aw_bad = 1'b0;
`endif

  assign unused_ok = ^{s_axi_araddr[4:0], s_axi_awaddr[4:0], s_axi_arsize, s_axi_arburst,
                       s_axi_awsize, s_axi_awburst, m_axi_rlast};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Read path
  assign s_axi_arready = live && (rd_state == RD_IDLE);
  assign m_axi_araddr  = rd_addr;
  assign m_axi_arlen   = rd_len;
  assign m_axi_arsize  = 3'b110;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid    = 1'b0;
  assign m_axi_arvalid = (rd_state == RD_ADDR);
  assign s_axi_rvalid  = (rd_state == RD_DATA) && (rd_err || m_axi_rvalid);
  assign s_axi_rdata   = rd_err ? 256'b0 : (rd_h ? m_axi_rdata[511:256] : m_axi_rdata[255:0]);
  assign s_axi_rresp   = rd_err ? 2'b10 : m_axi_rresp;
  assign s_axi_rid     = rd_id;
  assign s_axi_rlast   = (rd_state == RD_DATA) && (rd_n == 8'd0);
  // A master beat retires after its upper half, or early when the burst ends on a lower half.
  assign m_axi_rready  = (rd_state == RD_DATA) && !rd_err && s_axi_rready &&
                         (rd_h || (rd_n == 8'd0));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      rd_h     <= 1'b0;
      rd_n     <= 8'd0;
      rd_id    <= 1'b0;
      rd_err   <= 1'b0;
      rd_len   <= 8'd0;
      rd_addr  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (s_axi_arvalid && s_axi_arready) begin
          rd_h     <= s_axi_araddr[5];
          rd_n     <= s_axi_arlen;
          rd_id    <= s_axi_arid;
          rd_err   <= ar_bad;
          rd_addr  <= {s_axi_araddr[ADDR_BITS-1:6], 6'b0};
          rd_len   <= up_len(s_axi_araddr[5], s_axi_arlen);
          rd_state <= ar_bad ? RD_DATA : RD_ADDR;
        end
        RD_ADDR: if (m_axi_arready) rd_state <= RD_DATA;
        RD_DATA: if (s_axi_rvalid && s_axi_rready) begin
          rd_h <= ~rd_h;
          rd_n <= rd_n - 8'd1;
          if (rd_n == 8'd0) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write path
  assign wr_pass       = wr_h || s_axi_wlast;  // this slave beat completes a master beat
  assign s_axi_awready = live && (wr_state == WR_IDLE);
  assign m_axi_awaddr  = wr_addr;
  assign m_axi_awlen   = wr_len;
  assign m_axi_awsize  = 3'b110;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awid    = 1'b0;
  assign m_axi_awvalid = (wr_state == WR_ADDR);
  assign s_axi_wready  = (wr_state == WR_DATA) && (wr_err || !wr_pass || m_axi_wready);
  assign m_axi_wvalid  = (wr_state == WR_DATA) && !wr_err && wr_pass && s_axi_wvalid;
  assign m_axi_wdata   = wr_h ? {s_axi_wdata, buf_data} : {256'b0, s_axi_wdata};
  assign m_axi_wstrb   = wr_h ? {s_axi_wstrb, buf_strb} : {32'b0, s_axi_wstrb};
  assign m_axi_wlast   = s_axi_wlast;
  assign s_axi_bvalid  = (wr_state == WR_RESP) && (wr_err || m_axi_bvalid);
  assign s_axi_bresp   = wr_err ? 2'b10 : m_axi_bresp;
  assign s_axi_bid     = wr_id;
  assign m_axi_bready  = (wr_state == WR_RESP) && !wr_err && s_axi_bready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= WR_IDLE;
      wr_h     <= 1'b0;
      wr_id    <= 1'b0;
      wr_err   <= 1'b0;
      wr_len   <= 8'd0;
      wr_addr  <= '0;
      buf_data <= 256'b0;
      buf_strb <= 32'b0;
    end else begin
      case (wr_state)
        WR_IDLE: if (s_axi_awvalid && s_axi_awready) begin
          wr_h     <= s_axi_awaddr[5];
          wr_id    <= s_axi_awid;
          wr_err   <= aw_bad;
          wr_addr  <= {s_axi_awaddr[ADDR_BITS-1:6], 6'b0};
          wr_len   <= up_len(s_axi_awaddr[5], s_axi_awlen);
          buf_strb <= 32'b0;  // an unaligned first beat sees an empty lower half
          wr_state <= aw_bad ? WR_DATA : WR_ADDR;
        end
        WR_ADDR: if (m_axi_awready) wr_state <= WR_DATA;
        WR_DATA: if (s_axi_wvalid && s_axi_wready) begin
          if (!wr_err && !wr_pass) begin
            buf_data <= s_axi_wdata;
            buf_strb <= s_axi_wstrb;
            wr_h     <= 1'b1;
          end else begin
            buf_strb <= 32'b0;
            wr_h     <= 1'b0;
          end
          if (s_axi_wlast) wr_state <= WR_RESP;
        end
        WR_RESP: if (s_axi_bvalid && s_axi_bready) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hbm_narrow.sv
// tb/tb_hbm_narrow.sv - self-checking bench for hbm_narrow
module tb_hbm_narrow;
  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [63:0]   s_axi_araddr, s_axi_awaddr, m_axi_araddr, m_axi_awaddr;
  logic [7:0]    s_axi_arlen, s_axi_awlen, m_axi_arlen, m_axi_awlen;
  logic [2:0]    s_axi_arsize, s_axi_awsize, m_axi_arsize, m_axi_awsize;
  logic [1:0]    s_axi_arburst, s_axi_awburst, m_axi_arburst, m_axi_awburst;
  logic          s_axi_arid, s_axi_arvalid, s_axi_arready, s_axi_awid, s_axi_awvalid, s_axi_awready;
  logic [255:0]  s_axi_wdata, s_axi_rdata;
  logic [31:0]   s_axi_wstrb;
  logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic          s_axi_rid, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [1:0]    s_axi_rresp, s_axi_bresp, m_axi_rresp, m_axi_bresp;
  logic          s_axi_bid, s_axi_bvalid, s_axi_bready;
  logic          m_axi_arid, m_axi_arvalid, m_axi_arready, m_axi_awid, m_axi_awvalid, m_axi_awready;
  logic [511:0]  m_axi_wdata, m_axi_rdata;
  logic [63:0]   m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready, m_axi_bvalid, m_axi_bready;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  hbm_narrow #(.ADDR_BITS(64)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arid(s_axi_arid), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awid(s_axi_awid), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awid(m_axi_awid), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    int          len;
    int          mlen;   // hand-computed master len
    bit          bp;     // random backpressure
    bit          full;   // all-ones write strobes
    logic        id;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [511:0] rpat(input int k);
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[32*j +: 32] = {8'hC3, 8'(j), 16'(k)};
    return d;
  endfunction

  function automatic logic [255:0] wpat(input int i);
    logic [255:0] d;
    for (int j = 0; j < 8; j++) d[32*j +: 32] = {8'h5A, 8'(j), 16'(i)};
    return d;
  endfunction

  function automatic logic [31:0] spat(input int i, input bit full);
    logic [7:0] b;
    b = 8'(i);
    return full ? 32'hFFFF_FFFF : {b ^ 8'h5A, ~b, b, 8'hF0 | (b & 8'h0F)};
  endfunction

  function automatic logic rnd(input bit bp);
    return bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b101; s_axi_arburst = 2'b01;
    s_axi_arid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b101; s_axi_awburst = 2'b01;
    s_axi_awid = 1'b0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_bresp = '0; m_axi_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    logic [9:0] outs;
    aresetn = 1'b0;
    idle_inputs();
    #1;
    outs = {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid,
            m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready};
    chk(outs == 10'b0, "reset_outputs", 512'(outs), 512'(0));
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk(!s_axi_arready && !s_axi_awready, "ready_before_first_clk",
        512'({s_axi_arready, s_axi_awready}), 512'(0));
    @(negedge aclk);
    #1;
    chk(s_axi_arready && s_axi_awready, "ready_after_release",
        512'({s_axi_arready, s_axi_awready}), 512'(3));
  endtask

  task automatic watch_quiet(input int n, input string name);
    bit seen = 0;
    m_axi_bvalid = 1'b1; m_axi_wready = 1'b1; s_axi_bready = 1'b1;
    m_axi_rvalid = 1'b1; s_axi_rready = 1'b1;
    repeat (n) begin
      @(negedge aclk);
      #1;
      if (m_axi_wvalid || s_axi_bvalid || s_axi_rvalid || m_axi_arvalid || m_axi_awvalid) seen = 1;
    end
    chk(!seen, name, 512'(seen), 512'(0));
    idle_inputs();
  endtask

  task automatic run_read(input logic [63:0] addr, input int len, input int mlen, input bit bp,
                          input logic id, input bit bad);
    int i = 0, k = 0, nar = 0, cyc = 0, pos, kk;
    int a5 = int'(addr[5]);
    bit hs_ar = 0, hs_mar = 0, hs_r = 0, hs_mr = 0, mar_done = 0;
    logic [511:0] rp;
    logic [255:0] exp_d;
    logic [1:0]   exp_resp;
    while (cyc < 8000) begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1) begin
        s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = bad ? 3'b110 : 3'b101;
        s_axi_arburst = 2'b01; s_axi_arid = id; s_axi_arvalid = 1'b1;
      end
      if (hs_ar) s_axi_arvalid = 1'b0;
      if (hs_mar) mar_done = 1;
      if (hs_r) i++;
      if (hs_mr) begin k++; m_axi_rvalid = 1'b0; end
      if (i > len) break;
      m_axi_arready = rnd(bp);
      s_axi_rready  = rnd(bp);
      if (mar_done && k <= mlen && !m_axi_rvalid) m_axi_rvalid = rnd(bp);
      m_axi_rdata = rpat(k);
      m_axi_rresp = {1'b0, 1'(k & 1)};
      m_axi_rlast = (k == mlen);
      #1;
      hs_ar  = s_axi_arvalid && s_axi_arready;
      hs_mar = m_axi_arvalid && m_axi_arready;
      if (hs_mar) begin
        nar++;
        chk({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid} ==
            {addr & ~64'h3F, 8'(mlen), 3'b110, 2'b01, 1'b0}, "m_ar_fields",
            512'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid}),
            512'({addr & ~64'h3F, 8'(mlen), 3'b110, 2'b01, 1'b0}));
      end
      hs_r = s_axi_rvalid && s_axi_rready;
      if (hs_r) begin
        pos = a5 + i;
        kk = pos >> 1;
        rp = rpat(kk);
        exp_d = bad ? 256'b0 : ((pos & 1) != 0 ? rp[511:256] : rp[255:0]);
        exp_resp = bad ? 2'b10 : {1'b0, 1'(kk & 1)};
        chk(s_axi_rdata == exp_d && s_axi_rresp == exp_resp && s_axi_rid == id &&
            s_axi_rlast == (i == len), "r_beat",
            512'({s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast}),
            512'({exp_d, exp_resp, id, (i == len)}));
      end
      hs_mr = m_axi_rvalid && m_axi_rready;
    end
    chk(i > len, "r_burst_done", 512'(i), 512'(len + 1));
    chk(nar == (bad ? 0 : 1), "m_ar_count", 512'(nar), 512'(bad ? 0 : 1));
    chk(k == (bad ? 0 : mlen + 1), "m_r_consumed", 512'(k), 512'(bad ? 0 : mlen + 1));
    idle_inputs();
  endtask

  task automatic run_write(input logic [63:0] addr, input int len, input int mlen, input bit bp,
                           input bit full, input logic id, input bit bad);
    int i = 0, k = 0, naw = 0, cyc = 0, jl, ju;
    int a5 = int'(addr[5]);
    bit hs_aw = 0, hs_maw = 0, hs_w = 0, hs_mw = 0, hs_b = 0, lv, uv;
    logic [63:0]  exp_s;
    logic [255:0] exp_up, exp_lo;
    logic [1:0]   exp_b;
    while (cyc < 8000) begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1) begin
        s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = bad ? 3'b110 : 3'b101;
        s_axi_awburst = 2'b01; s_axi_awid = id; s_axi_awvalid = 1'b1;
      end
      if (hs_aw) s_axi_awvalid = 1'b0;
      if (hs_w) begin i++; s_axi_wvalid = 1'b0; end
      if (hs_mw) k++;
      if (hs_b) break;
      m_axi_awready = rnd(bp);
      m_axi_wready  = rnd(bp);
      s_axi_bready  = rnd(bp);
      if (i <= len && !s_axi_wvalid) s_axi_wvalid = rnd(bp);
      s_axi_wdata = wpat(i);
      s_axi_wstrb = spat(i, full);
      s_axi_wlast = (i == len);
      if (!bad && k == mlen + 1) m_axi_bvalid = 1'b1;
      m_axi_bresp = {1'b0, id};
      #1;
      hs_aw  = s_axi_awvalid && s_axi_awready;
      hs_maw = m_axi_awvalid && m_axi_awready;
      if (hs_maw) begin
        naw++;
        chk({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid} ==
            {addr & ~64'h3F, 8'(mlen), 3'b110, 2'b01, 1'b0}, "m_aw_fields",
            512'({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid}),
            512'({addr & ~64'h3F, 8'(mlen), 3'b110, 2'b01, 1'b0}));
      end
      hs_w  = s_axi_wvalid && s_axi_wready;
      hs_mw = m_axi_wvalid && m_axi_wready;
      if (hs_mw) begin
        jl = 2 * k - a5;
        ju = jl + 1;
        lv = (jl >= 0) && (jl <= len);
        uv = (ju >= 0) && (ju <= len);
        exp_s  = {uv ? spat(ju, full) : 32'h0, lv ? spat(jl, full) : 32'h0};
        exp_up = uv ? wpat(ju) : 256'b0;
        exp_lo = lv ? wpat(jl) : 256'b0;
        chk(m_axi_wstrb == exp_s && m_axi_wdata[511:256] == exp_up &&
            (!lv || m_axi_wdata[255:0] == exp_lo) && m_axi_wlast == (k == mlen) && k <= mlen,
            "m_w_beat",
            512'({m_axi_wlast, m_axi_wstrb, m_axi_wdata[511:256]}),
            512'({(k == mlen), exp_s, exp_up}));
      end
      hs_b = s_axi_bvalid && s_axi_bready;
      if (hs_b) begin
        exp_b = bad ? 2'b10 : {1'b0, id};
        chk(s_axi_bid == id && s_axi_bresp == exp_b, "b_resp",
            512'({s_axi_bid, s_axi_bresp}), 512'({id, exp_b}));
      end
    end
    chk(hs_b, "b_done", 512'(hs_b), 512'(1));
    chk(naw == (bad ? 0 : 1), "m_aw_count", 512'(naw), 512'(bad ? 0 : 1));
    chk(k == (bad ? 0 : mlen + 1), "m_w_count", 512'(k), 512'(bad ? 0 : mlen + 1));
    chk(i == len + 1, "s_w_count", 512'(i), 512'(len + 1));
    idle_inputs();
  endtask

  task automatic reset_mid_write();
    int i = 0, cyc = 0;
    bit hs_aw = 0, hs_w = 0;
    while (cyc < 100) begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1) begin
        s_axi_awaddr = 64'h9000; s_axi_awlen = 8'd7; s_axi_awid = 1'b1; s_axi_awvalid = 1'b1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      end
      if (hs_aw) s_axi_awvalid = 1'b0;
      if (hs_w) i++;
      s_axi_wvalid = 1'b1;
      s_axi_wdata = wpat(i);
      s_axi_wstrb = 32'hFFFF_FFFF;
      s_axi_wlast = 1'b0;
      if (i == 2) break;
      #1;
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
    end
    chk(i == 2, "pre_reset_beats", 512'(i), 512'(2));
    #1;
    do_reset();
    watch_quiet(12, "no_residual_after_write_reset");
  endtask

  task automatic dual_accept();
    @(negedge aclk);
    s_axi_araddr = 64'hA000; s_axi_arlen = 8'd1; s_axi_arvalid = 1'b1;
    s_axi_awaddr = 64'hB020; s_axi_awlen = 8'd1; s_axi_awvalid = 1'b1;
    #1;
    chk(s_axi_arready && s_axi_awready, "dual_accept",
        512'({s_axi_arready, s_axi_awready}), 512'(3));
    @(negedge aclk);
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    #1;
    chk(m_axi_arvalid && m_axi_awvalid, "dual_master_req",
        512'({m_axi_arvalid, m_axi_awvalid}), 512'(3));
    do_reset();
    watch_quiet(6, "no_residual_after_dual_reset");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 64'h1000, 3, 1, 0, 0, 1'b0};
    vecs[1]  = '{0, 64'h1020, 0, 0, 0, 0, 1'b1};
    vecs[2]  = '{1, 64'h2020, 1, 1, 0, 1, 1'b1};
    vecs[3]  = '{0, 64'h1020, 2, 1, 0, 0, 1'b0};
    vecs[4]  = '{1, 64'h3000, 0, 0, 0, 0, 1'b0};
    vecs[5]  = '{1, 64'h3000, 2, 1, 0, 0, 1'b1};
    vecs[6]  = '{0, 64'h4000, 255, 127, 1, 0, 1'b1};
    vecs[7]  = '{1, 64'h5020, 255, 128, 1, 0, 1'b0};
    vecs[8]  = '{0, 64'h6020, 255, 128, 1, 0, 1'b0};
    vecs[9]  = '{1, 64'h7000, 255, 127, 1, 1, 1'b1};
    vecs[10] = '{1, 64'h2020, 4, 2, 1, 0, 1'b0};
    vecs[11] = '{0, 64'hFFFF_0000_0000_1060, 5, 3, 1, 0, 1'b1};

    do_reset();
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].wr)
        run_write(vecs[v].addr, vecs[v].len, vecs[v].mlen, vecs[v].bp, vecs[v].full, vecs[v].id, 1'b0);
      else
        run_read(vecs[v].addr, vecs[v].len, vecs[v].mlen, vecs[v].bp, vecs[v].id, 1'b0);
    end

    dual_accept();
    reset_mid_write();
    run_write(64'h9000, 7, 3, 1, 0, 1'b1, 1'b0);
    run_read(64'h9020, 7, 4, 1, 1'b0, 1'b0);

`ifdef HBM_NARROW_BURST_CHECK_EN
    run_read(64'hC000, 2, 0, 1, 1'b1, 1'b1);
    run_write(64'hD000, 3, 0, 1, 0, 1'b1, 1'b1);
    run_read(64'hC020, 1, 1, 0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbm_narrow.md
HBM_NARROW -- requirements
Module: hbm_narrow

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 64, meaning slave and master address width.
REQ-002 SHALL have port aclk, input, 1, sole clock; all logic rising-edge.
REQ-003 SHALL have port aresetn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have s_axi_ar* ports, slave AR channel: araddr ADDR_BITS, arlen 8, arsize 3, arburst 2, arid 1, arvalid in, arready out.
REQ-005 SHALL have s_axi_aw* ports, slave AW channel: same fields as AR with aw prefix.
REQ-006 SHALL have s_axi_w* ports, slave W channel: wdata 256, wstrb 32, wlast 1, wvalid in, wready out.
REQ-007 SHALL have s_axi_r* ports, slave R channel out: rdata 256, rid 1, rresp 2, rlast 1, rvalid out, rready in.
REQ-008 SHALL have s_axi_b* ports, slave B channel out: bid 1, bresp 2, bvalid out, bready in.
REQ-009 SHALL have m_axi_* ports, one 512-bit AXI4 master: AR/AW (addr ADDR_BITS, len 8, size 3, burst 2, id 1, valid, ready), W (wdata 512, wstrb 64, wlast, wvalid, wready), R (rdata 512, rresp, rlast, rvalid, rready), B (bresp, bvalid, bready).

Function
REQ-010 SHALL upsize 256-bit INCR bursts (32 B beats, 32 B aligned) onto 512-bit INCR bursts (64 B beats); one outstanding transaction per direction; read and write paths independent.
REQ-011 SHALL compute master address = slave address with bits [5:0] cleared; master len = (addr[5] + slave len) >> 1 in 9-bit arithmetic; master size = 3'b110; burst = INCR; id = 0.
REQ-012 Read FSM RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE; s_axi_arready = 1 only in RD_IDLE.
REQ-013 On AR handshake: register addr[5] as half pointer h, slave len as remaining count n, arid; enter RD_ADDR; m_axi_arvalid asserted the next cycle, held until m_axi_arready, then RD_DATA.
REQ-014 In RD_DATA: s_axi_rdata = h ? m_rdata[511:256] : m_rdata[255:0]; s_axi_rvalid = m_axi_rvalid; rresp passthrough; rid = registered arid; s_axi_rlast = (n == 0).
REQ-015 m_axi_rready = s_axi_rready AND (h == 1 OR n == 0); each slave R handshake toggles h and decrements n; master rlast ignored.
REQ-016 Slave R handshake with n == 0 SHALL return read FSM to RD_IDLE; a new AR is accepted no earlier than the following cycle.
REQ-017 Write FSM WR_IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> WR_IDLE; s_axi_awready = 1 only in WR_IDLE; s_axi_wready = 0 outside WR_DATA.
REQ-018 AW handling mirrors REQ-013 (h from awaddr[5], awid registered); WR_DATA entered after m_axi_aw handshake.
REQ-019 In WR_DATA with h == 0 and s_axi_wlast == 0: beat stored in 256-bit half-buffer plus 32-bit strobe buffer, s_axi_wready = 1, no master beat.
REQ-020 In WR_DATA with h == 1 or s_axi_wlast == 1: m_axi_wvalid = s_axi_wvalid, s_axi_wready = m_axi_wready; master beat = {current, buffer} if h == 1, {zero, current} if h == 0; m_axi_wlast = s_axi_wlast.
REQ-021 Unfilled half of any master beat SHALL carry wstrb 0: lower half of first beat when addr[5] = 1; upper half of last beat when the burst ends on h == 0. Half-buffer strobes clear after each master beat.
REQ-022 Master W handshake with wlast SHALL enter WR_RESP; s_axi_bvalid = m_axi_bvalid, m_axi_bready = s_axi_bready, bresp passthrough, bid = registered awid; B handshake returns to WR_IDLE.
REQ-023 Simultaneous AR and AW handshakes in the same cycle SHALL both be accepted.

Reset
REQ-024 aresetn low SHALL immediately force RD_IDLE and WR_IDLE, clear h, n, buffers and registered ids; all valid and ready outputs 0 during reset except s_axi_arready and s_axi_awready, which are 1 from the first clock after release.
REQ-025 Reset mid-burst SHALL abandon the transaction; no residual beat or response SHALL be issued after release.

Configuration
REQ-026 With HBM_NARROW_BURST_CHECK_EN defined: AR/AW with size != 3'b101 or burst != INCR SHALL produce no master request; reads return len+1 beats of zero data with SLVERR; writes consume all W beats, then return SLVERR on B.
REQ-027 Without HBM_NARROW_BURST_CHECK_EN: size and burst inputs SHALL be ignored and every request treated as 32 B INCR.

Verification
REQ-028 AR addr 0x1000 len 3 -> master AR addr 0x1000 len 1; 4 slave beats low, high, low, high; rlast on beat 4 only.
REQ-029 AR addr 0x1020 len 0 -> master len 0; single slave beat = m_rdata[511:256], rlast 1; master beat consumed.
REQ-030 AW addr 0x2020 len 1, wstrb all ones -> master len 1; beat 0 strb 0xFFFFFFFF_00000000, beat 1 strb 0x00000000_FFFFFFFF, wlast on beat 1; one B forwarded with bid = awid.
REQ-031 Random rready/wready/m_rvalid/m_wready backpressure over 256-beat bursts -> data order and strobes bit-exact against reference model; no beat lost or duplicated.
REQ-032 aresetn low during write beat 2 of len 7 -> after release, no m_axi_wvalid or s_axi_bvalid; a new AW accepted and completes normally.
REQ-033 With HBM_NARROW_BURST_CHECK_EN, AR arsize 3'b110 len 2 -> no m_axi_arvalid; 3 beats rresp 2'b10, rdata 0.
